// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch/flush pipeline stage.
// Holds the NOP opcode, the flush FSM state encoding and default bus widths.
package fetch_pkg;

    localparam int FETCH_DATA_W = 8;
    localparam int FETCH_ADDR_W = 8;
    localparam logic [7:0] NOP_OPCODE = 8'hC8;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } fetch_state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? 8'hFF : value + 8'd1;
    endfunction

endpackage

// File: rtl/fetch_flush_ctrl.sv
// Flush controller: RUN/FLUSH state machine, remaining-squash counter and
// saturating flush-event counter. flush_now squashes in the jump cycle itself.
module flush_ctrl
    import fetch_pkg::*;
#(
    parameter int FLUSH_DEPTH = 2
) (
    input  logic         clk,
    input  logic         sync_reset,
    input  logic         taken,
    input  logic         stall,
    output logic         flush_now,
    output logic [7:0]   count,
    output fetch_state_t state
);

    localparam logic [3:0] REM_LOAD = 4'(FLUSH_DEPTH - 1);
    localparam bit NEEDS_FLUSH_STATE = (FLUSH_DEPTH > 1);

    fetch_state_t state_next;
    logic [3:0]   rem, rem_next;
    logic [7:0]   count_next;

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            state <= RUN;
            rem   <= 4'd0;
            count <= 8'd0;
        end else begin
            state <= state_next;
            rem   <= rem_next;
            count <= count_next;
        end
    end

    // rem counts the squash cycles still owed, including the current FLUSH
    // cycle; the jump cycle is squashed combinationally before FLUSH starts.
    always_comb begin
        state_next = state;
        rem_next   = rem;
        count_next = count;
        case (state)
            RUN: begin
                if (taken) begin
                    count_next = sat_inc8(count);
                    if (NEEDS_FLUSH_STATE) begin
                        state_next = FLUSH;
                        rem_next   = REM_LOAD;
                    end
                end
            end
            FLUSH: begin
                if (taken) begin
                    rem_next   = REM_LOAD;
                    count_next = sat_inc8(count);
                end else if (stall) begin
                    state_next = FLUSH;
                end else if (rem <= 4'd1) begin
                    state_next = RUN;
                    rem_next   = 4'd0;
                end else begin
                    rem_next = rem - 4'd1;
                end
            end
            default: begin
                state_next = RUN;
                rem_next   = 4'd0;
            end
        endcase
    end

    assign flush_now = taken | (state == FLUSH);

endmodule

// File: rtl/fetch_flush_pipe.sv
// Fetch-to-decode pipeline register with taken-jump squashing and decode stall.
// Data, address and valid are registered; the NOP override is combinational.
module fetch_flush_pipe #(
    parameter int                  DATA_W      = fetch_pkg::FETCH_DATA_W,
    parameter int                  ADDR_W      = fetch_pkg::FETCH_ADDR_W,
    parameter logic [DATA_W-1:0]   NOP_OPCODE  = DATA_W'(fetch_pkg::NOP_OPCODE),
    parameter int                  FLUSH_DEPTH = 2
) (
    input  logic              clk,
    input  logic              sync_reset,
    input  logic [DATA_W-1:0] pm_data_in,
    input  logic [ADDR_W-1:0] pm_address_in,
    input  logic              jump,
    input  logic              conditional_jump,
    input  logic              zero_flag,
    input  logic              stall,
    output logic [DATA_W-1:0] id_data_out,
    output logic [ADDR_W-1:0] id_address_out,
    output logic              id_valid,
    output logic              flush_active,
    output logic [7:0]        flush_count
);

    import fetch_pkg::*;

    logic [DATA_W-1:0] data_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic              valid_reg;
    logic              taken;
    logic              flush_now;
    fetch_state_t      fsm_state;

    // zero_flag is a dont-jump flag: a conditional jump is taken only when it is low.
    assign taken = (jump | (conditional_jump & ~zero_flag)) & ~stall;

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            data_reg  <= NOP_OPCODE;
            addr_reg  <= '0;
            valid_reg <= 1'b0;
        end else if (!stall) begin
            data_reg  <= pm_data_in;
            addr_reg  <= pm_address_in;
            valid_reg <= 1'b1;
        end
    end

    flush_ctrl #(
        .FLUSH_DEPTH (FLUSH_DEPTH)
    ) u_flush_ctrl (
        .clk        (clk),
        .sync_reset (sync_reset),
        .taken      (taken),
        .stall      (stall),
        .flush_now  (flush_now),
        .count      (flush_count),
        .state      (fsm_state)
    );

    // A FLUSH state must always be squashing the presented word.
    always_ff @(posedge clk) begin
        if (!sync_reset) begin
            assert (!(fsm_state == FLUSH) || flush_now);
        end
    end

    assign id_data_out    = flush_now ? NOP_OPCODE : data_reg;
    assign id_address_out = addr_reg;
    assign flush_active   = flush_now;
    assign id_valid       = valid_reg & ~flush_now;

endmodule
